// File: rtl/alu_seq_if.sv
// Handshake and result/flag bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) ();
    logic             start;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic             err;

    modport master (output start, sel, in_A, in_B,
                    input  busy, done, result, N, Z, C, V, err);
    modport slave  (input  start, sel, in_A, in_B,
                    output busy, done, result, N, Z, C, V, err);
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle ops, bit-serial shifts and shift-add multiply,
// with a start/busy/done handshake and N/Z/C/V flags plus an illegal-opcode strobe.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int LG = $clog2(WIDTH);
    localparam int CW = LG + 1;

    localparam logic [SEL_W-1:0] OP_NOP   = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_ADD   = SEL_W'(1);
    localparam logic [SEL_W-1:0] OP_SUB   = SEL_W'(2);
    localparam logic [SEL_W-1:0] OP_NAND  = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_SHL   = SEL_W'(4);
    localparam logic [SEL_W-1:0] OP_SHR   = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_OUT   = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_IN    = SEL_W'(7);
    localparam logic [SEL_W-1:0] OP_MOV   = SEL_W'(8);
    localparam logic [SEL_W-1:0] OP_MUL   = SEL_W'(9);
    localparam logic [SEL_W-1:0] OP_STORE = SEL_W'(14);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_op;
    logic [WIDTH-1:0] r_work, r_mplr, r_acc, r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_n, r_z, r_c, r_v, r_err;

    logic [LG-1:0]    w_k;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [WIDTH-1:0] w_shf, w_acc_nxt, w_res;
    logic             w_sout, w_load, w_upd_res, w_upd_c, w_upd_v, w_c, w_v, w_err;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign w_k       = bus.in_B[LG-1:0];
    assign w_sum     = {1'b0, bus.in_A} + {1'b0, bus.in_B};
    assign w_dif     = {1'b0, bus.in_A} - {1'b0, bus.in_B};
    assign w_shf     = (r_op == OP_SHL) ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};
    assign w_sout    = (r_op == OP_SHL) ? r_work[WIDTH-1] : r_work[0];
    assign w_acc_nxt = r_mplr[0] ? (r_acc + r_work) : r_acc;

    // Result and flags are captured on the edge that enters DONE, so they are valid with done.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_upd_res   = 1'b0;
        w_res       = '0;
        w_upd_c     = 1'b0;
        w_c         = 1'b0;
        w_upd_v     = 1'b0;
        w_v         = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_DONE;
                    case (bus.sel)
                        OP_NOP: begin end
                        OP_ADD: begin
                            w_upd_res = 1'b1;
                            w_res     = w_sum[WIDTH-1:0];
                            w_upd_c   = 1'b1;
                            w_c       = w_sum[WIDTH];
                            w_upd_v   = 1'b1;
                            w_v       = add_ovf(bus.in_A, bus.in_B, w_sum[WIDTH-1:0]);
                        end
                        OP_SUB: begin
                            w_upd_res = 1'b1;
                            w_res     = w_dif[WIDTH-1:0];
                            w_upd_c   = 1'b1;
                            w_c       = w_dif[WIDTH];
                            w_upd_v   = 1'b1;
                            w_v       = sub_ovf(bus.in_A, bus.in_B, w_dif[WIDTH-1:0]);
                        end
                        OP_NAND: begin
                            w_upd_res = 1'b1;
                            w_res     = ~(bus.in_A & bus.in_B);
                        end
                        OP_OUT, OP_STORE: begin
                            w_upd_res = 1'b1;
                            w_res     = bus.in_A;
                        end
                        OP_IN: w_upd_res = 1'b1;
                        OP_MOV: begin
                            w_upd_res = 1'b1;
                            w_res     = bus.in_B;
                        end
                        OP_SHL, OP_SHR: begin
                            if (w_k == '0) begin
                                w_upd_res = 1'b1;
                                w_res     = bus.in_A;
                                w_upd_c   = 1'b1;
                            end else begin
                                w_load      = 1'b1;
                                w_state_nxt = S_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            w_load      = 1'b1;
                            w_state_nxt = S_MUL;
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                    w_upd_res   = 1'b1;
                    w_res       = w_shf;
                    w_upd_c     = 1'b1;
                    w_c         = w_sout;
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                    w_upd_res   = 1'b1;
                    w_res       = w_acc_nxt;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_work   <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_load) begin
                r_op   <= bus.sel;
                r_work <= bus.in_A;
                r_mplr <= bus.in_B;
                r_acc  <= '0;
                r_cnt  <= (bus.sel == OP_MUL) ? CW'(WIDTH) : {1'b0, w_k};
            end else if (r_state == S_SHIFT) begin
                r_work <= w_shf;
                r_cnt  <= r_cnt - CW'(1);
            end else if (r_state == S_MUL) begin
                r_acc  <= w_acc_nxt;
                r_work <= {r_work[WIDTH-2:0], 1'b0};
                r_mplr <= {1'b0, r_mplr[WIDTH-1:1]};
                r_cnt  <= r_cnt - CW'(1);
            end
            if (w_upd_res) begin
                r_result <= w_res;
                r_n      <= w_res[WIDTH-1];
                r_z      <= (w_res == '0);
            end
            if (w_upd_c) r_c <= w_c;
            if (w_upd_v) r_v <= w_v;
        end
    end

    assign bus.busy   = (r_state == S_SHIFT) || (r_state == S_MUL);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.N      = r_n;
    assign bus.Z      = r_z;
    assign bus.C      = r_c;
    assign bus.V      = r_v;
    assign bus.err    = r_err;
endmodule
